imm_encode: RTL and testbench

IMM_ENCODE -- requirements
Module: imm_encode

---
 rtl/imm_encode.sv | 144 ++++++++++++++
 tb/tb_imm_encode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// Two-stage immediate-field encoder: S1 captures the value and its fit flags, S2 packs the field.
// Optional macro IMM_ENCODE_AUTO_EN selects the narrowest fitting format instead of using msb_i.
module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value_i,
    input  logic [1:0]  msb_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] imm_o,
    output logic [1:0]  msb_o,
    output logic        ovf_o,
    output logic [7:0]  ovf_cnt
);

    localparam logic [1:0] EXT16 = 2'd0;
    localparam logic [1:0] EXT17 = 2'd1;
    localparam logic [1:0] EXT22 = 2'd2;
    localparam logic [1:0] EXT23 = 2'd3;

    // A value fits N bits when everything from bit N-1 upward is pure sign extension.
    function automatic logic [3:0] fit_flags(input logic signed [31:0] v);
        fit_flags[0] = (&v[31:15]) | ~(|v[31:15]);
        fit_flags[1] = (&v[31:16]) | ~(|v[31:16]);
        fit_flags[2] = (&v[31:21]) | ~(|v[31:21]);
        fit_flags[3] = (&v[31:22]) | ~(|v[31:22]);
    endfunction

    function automatic logic [22:0] pack_field(input logic [22:0] v, input logic [1:0] code);
        case (code)
            EXT16:   pack_field = {7'd0, v[15:0]};
            EXT17:   pack_field = {6'd0, v[16:0]};
            EXT22:   pack_field = {1'b0, v[21:0]};
            default: pack_field = v;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic        s1_vld_q, s1_vld_d;
    logic [22:0] s1_val_q, s1_val_d;
    logic [3:0]  s1_fit_q, s1_fit_d;
`ifndef IMM_ENCODE_AUTO_EN
    logic [1:0]  s1_code_q, s1_code_d;
`endif
    logic        s2_vld_q, s2_vld_d;
    logic [22:0] s2_imm_q, s2_imm_d;
    logic [1:0]  s2_code_q, s2_code_d;
    logic        s2_ovf_q, s2_ovf_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        s2_adv, in_hs, out_hs;
    logic [1:0]  sel_code;
    logic        sel_ovf;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign in_ready = reset && (!s1_vld_q || s2_adv);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = s2_vld_q && out_ready;

    // ---- S1 -> S2 boundary: format selection from registered fit flags
    always_comb begin
`ifdef IMM_ENCODE_AUTO_EN
        sel_code = EXT23;
        if (s1_fit_q[2]) sel_code = EXT22;
        if (s1_fit_q[1]) sel_code = EXT17;
        if (s1_fit_q[0]) sel_code = EXT16;
        sel_ovf  = !s1_fit_q[3];
`else
        sel_code = s1_code_q;
        sel_ovf  = !s1_fit_q[s1_code_q];
`endif
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_val_d  = s1_val_q;
        s1_fit_d  = s1_fit_q;
`ifndef IMM_ENCODE_AUTO_EN
        s1_code_d = s1_code_q;
`endif
        if (in_ready) s1_vld_d = in_valid;
        if (in_hs) begin
            s1_val_d  = value_i[22:0];
            s1_fit_d  = fit_flags(value_i);
`ifndef IMM_ENCODE_AUTO_EN
            s1_code_d = msb_i;
`endif
        end

        s2_vld_d  = s2_vld_q;
        s2_imm_d  = s2_imm_q;
        s2_code_d = s2_code_q;
        s2_ovf_d  = s2_ovf_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_imm_d  = pack_field(s1_val_q, sel_code);
                s2_code_d = sel_code;
                s2_ovf_d  = sel_ovf;
            end
        end

        cnt_d = (out_hs && s2_ovf_q) ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_imm_q  <= '0;
            s2_code_q <= EXT16;
            s2_ovf_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            s2_imm_q  <= s2_imm_d;
            s2_code_q <= s2_code_d;
            s2_ovf_q  <= s2_ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    // S1 payload is qualified by s1_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_val_q  <= s1_val_d;
        s1_fit_q  <= s1_fit_d;
`ifndef IMM_ENCODE_AUTO_EN
        s1_code_q <= s1_code_d;
`endif
    end

    assign out_valid = s2_vld_q;
    assign imm_o     = s2_imm_q;
    assign msb_o     = s2_code_q;
    assign ovf_o     = s2_ovf_q;
    assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// Randomized bench for imm_encode against an arithmetic range/modulo reference model.
module tb_imm_encode;

    localparam logic [1:0] EXT16 = 2'd0;
    localparam logic [1:0] EXT17 = 2'd1;
    localparam logic [1:0] EXT22 = 2'd2;
    localparam logic [1:0] EXT23 = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value_i = '0;
    logic [1:0]  msb_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] imm_o;
    logic [1:0]  msb_o;
    logic        ovf_o;
    logic [7:0]  ovf_cnt;

    imm_encode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .value_i(value_i), .msb_i(msb_i), .out_valid(out_valid), .out_ready(out_ready),
        .imm_o(imm_o), .msb_o(msb_o), .ovf_o(ovf_o), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] imm;
        logic [1:0]  msb;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   mcnt = 0;
    bit   hold_prev = 0;
    bit   last_rdy = 0;
    logic [25:0] held = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int wid(input logic [1:0] c);
        case (c)
            2'd0: return 16;
            2'd1: return 17;
            2'd2: return 22;
            default: return 23;
        endcase
    endfunction

    function automatic bit in_range(input longint sv, input int n);
        longint lim = longint'(1) << (n - 1);
        return (sv >= -lim) && (sv < lim);
    endfunction

    function automatic exp_t model(input logic [31:0] v, input logic [1:0] m);
        exp_t   e;
        longint sv = longint'($signed(v));
        int     n;
`ifdef IMM_ENCODE_AUTO_EN
        e.msb = EXT23;
        for (int i = 3; i >= 0; i--)
            if (in_range(sv, wid(2'(i)))) e.msb = 2'(i);
`else
        e.msb = m;
`endif
        n = wid(e.msb);
        e.ovf = !in_range(sv, n);
        e.imm = 23'(sv & ((longint'(1) << n) - 1));
        return e;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] b;
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return 32'($signed($urandom) >>> $urandom_range(8, 24));
            default: begin
                b = 32'd1 << (wid(2'($urandom_range(0, 3))) - 1);
                case ($urandom_range(0, 3))
                    0: return b;
                    1: return b - 32'd1;
                    2: return -b;
                    default: return -b - 32'd1;
                endcase
            end
        endcase
    endfunction

    // One cycle: drive at negedge, check/score just after, advance to next negedge.
    task automatic step(input bit iv, input logic [31:0] v, input logic [1:0] m,
                        input bit ordy, output bit acc);
        exp_t e;
        in_valid = iv; value_i = v; msb_i = m; out_ready = ordy;
        #1;
        check("ovf_cnt", ovf_cnt, mcnt);
        if (hold_prev) begin
            check("hold_vld", out_valid, 1);
            check("hold_data", {imm_o, msb_o, ovf_o}, held);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("stale_out", out_valid, 0);
            else begin
                e = q.pop_front();
                check("imm_o", imm_o, e.imm);
                check("msb_o", msb_o, e.msb);
                check("ovf_o", ovf_o, e.ovf);
                if (e.ovf && mcnt < 255) mcnt++;
            end
        end
        last_rdy = in_ready;
        acc = iv && in_ready;
        if (acc) q.push_back(model(v, m));
        hold_prev = out_valid && !out_ready;
        held = {imm_o, msb_o, ovf_o};
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_imm", imm_o, 0);
        check("rst_msb", msb_o, EXT16);
        check("rst_ovf", ovf_o, 0);
        check("rst_cnt", ovf_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        q.delete(); mcnt = 0; hold_prev = 0;
        @(negedge clk);
        reset = 1; out_ready = 1;
        #1 check("rdy_after_rst", in_ready, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int c = 0; c < 20 && q.size() > 0; c++) step(0, 0, 0, 1, acc);
        check("drain", q.size(), 0);
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] vals[4];
        logic [1:0]  ms[4];
        logic [31:0] av[3];
        logic [1:0]  am[3];
        logic        ao[3];

        @(negedge clk);
        do_reset();

`ifndef IMM_ENCODE_AUTO_EN
        step(1, 32'hFFFF8000, EXT16, 1, acc);
        step(0, 0, 0, 1, acc);
        #1;
        check("lat_vld", out_valid, 1);
        check("neg_imm", imm_o, 23'h008000);
        check("neg_msb", msb_o, EXT16);
        check("neg_ovf", ovf_o, 0);
        drain();

        do_reset();
        step(1, 32'h00008000, EXT16, 1, acc);
        step(1, 32'h00008000, EXT17, 1, acc);
        #1;
        check("pos16_imm", imm_o, 23'h008000);
        check("pos16_ovf", ovf_o, 1);
        step(0, 0, 0, 1, acc);
        #1;
        check("pos16_cnt", ovf_cnt, 1);
        check("pos17_ovf", ovf_o, 0);
        drain();
`else
        av = '{32'hFFE00000, 32'h00200000, 32'h7FFFFFFF};
        am = '{EXT22, EXT23, EXT23};
        ao = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1, av[i], EXT16, 1, acc);
            step(0, 0, 0, 1, acc);
            #1;
            check("auto_msb", msb_o, am[i]);
            check("auto_ovf", ovf_o, ao[i]);
            drain();
        end
`endif

        // back-pressure: four inputs, output stalled for five cycles
        for (int i = 0; i < 4; i++) begin
            vals[i] = rand_val();
            ms[i] = 2'($urandom_range(0, 3));
        end
        idx = 0;
        for (int c = 0; c < 40 && !(idx == 4 && q.size() == 0); c++) begin
            step(idx < 4, (idx < 4) ? vals[idx] : 32'd0, (idx < 4) ? ms[idx] : 2'd0, c >= 5, acc);
            if (acc) idx++;
            if (c >= 2 && c <= 4) check("bp_in_ready", last_rdy, 0);
        end
        check("bp_accepted", idx, 4);
        check("bp_drained", q.size(), 0);

        // reset with two items in flight
        step(1, rand_val(), 2'($urandom_range(0, 3)), 0, acc);
        step(1, rand_val(), 2'($urandom_range(0, 3)), 0, acc);
        do_reset();
        for (int c = 0; c < 6; c++) step(0, 0, 0, 1, acc);

        // randomized traffic
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 3) != 0, rand_val(), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, acc);
        drain();

        // counter saturation
        do_reset();
        idx = 0;
        for (int c = 0; c < 400 && !(idx == 260 && q.size() == 0); c++) begin
            step(idx < 260, 32'h7FFFFFFF, EXT16, 1, acc);
            if (acc) idx++;
        end
        check("sat_accepted", idx, 260);
        check("sat_cnt", ovf_cnt, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
